// File: rtl/itf_isa_tx_pkg.sv
// Shared ISA definitions for the instruction interface and the config unit:
// opcode encodings, per-opcode beat lengths and the TX state encoding.
package itf_isa_tx_pkg;

   localparam int ISA_OPCODE_WIDTH = 8;
   localparam int ISA_LEN_WIDTH    = 5;

   typedef enum logic [ISA_OPCODE_WIDTH-1:0] {
      OP_FPS = 8'd0,
      OP_KNN = 8'd1,
      OP_SYA = 8'd2,
      OP_POL = 8'd3,
      OP_GIC = 8'd4,
      OP_MON = 8'd5
   } opcode_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_HEAD = 2'd1,
      ST_BODY = 2'd2
   } txState_e;

   // Beats per instruction including the head; 0 marks an unknown opcode.
   function automatic logic [ISA_LEN_WIDTH-1:0] opLength(input logic [ISA_OPCODE_WIDTH-1:0] op);
      case (op)
         OP_FPS:  opLength = 5'd16;
         OP_KNN:  opLength = 5'd2;
         OP_SYA:  opLength = 5'd3;
         OP_POL:  opLength = 5'd9;
         OP_GIC:  opLength = 5'd2;
         OP_MON:  opLength = 5'd1;
         default: opLength = 5'd0;
      endcase
   endfunction

endpackage

// File: rtl/itf_isa_tx.sv
// ISA word framer: splits the DRAM ISA stream into instructions, 1-cycle registered output, upstream stalls on a full stage.
// ITF_ISA_TX_CFGRDY_GATE_EN: hold each legal head until the config unit reports ready for its opcode.
module itf_isa_tx
   import itf_isa_tx_pkg::*;
#(
   parameter int PORT_WIDTH   = 128,
   parameter int OPNUM        = 6,
   parameter int OPCODE_WIDTH = ISA_OPCODE_WIDTH,
   parameter int CNT_WIDTH    = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [PORT_WIDTH-1:0] SRCITF_IsaDat,
   input  logic                  SRCITF_IsaVld,
   output logic                  ITFSRC_IsaRdy,
   input  logic [OPNUM-1:0]      CCUITF_CfgRdy,
   output logic [PORT_WIDTH-1:0] ITFCCU_ISARdDat,
   output logic                  ITFCCU_ISARdDatVld,
   output logic                  ITFCCU_ISARdDatLast,
   input  logic                  CCUITF_ISARdDatRdy,
   output logic [CNT_WIDTH-1:0]  ITFMON_IsaCnt,
   output logic                  ITFMON_Err,
   output logic [1:0]            ITFMON_State
);

   txState_e                 state, stateNxt;
   logic [ISA_LEN_WIDTH-1:0] beatCnt, beatCntNxt;
   logic [OPCODE_WIDTH-1:0]  headOp;
   logic [ISA_LEN_WIDTH-1:0] headLen;
   logic                     headLegal;
   logic                     headGo;
   logic                     outFree;
   logic                     accept;
   logic                     fwd;
   logic                     fwdLast;
   logic                     errNxt;

   assign headOp    = SRCITF_IsaDat[OPCODE_WIDTH-1:0];
   assign headLen   = opLength(ISA_OPCODE_WIDTH'(headOp));
   assign headLegal = (int'(headOp) < OPNUM);
   assign outFree   = !ITFCCU_ISARdDatVld || CCUITF_ISARdDatRdy;

`ifdef ITF_ISA_TX_CFGRDY_GATE_EN
   logic cfgBit;

   always_comb begin
      cfgBit = 1'b0;
      for (int i = 0; i < OPNUM; i++) begin
         if (int'(headOp) == i) cfgBit = CCUITF_CfgRdy[i];
      end
   end

   // Illegal opcodes have no target to wait for, so they drop straight away.
   assign headGo = !headLegal || cfgBit;
`else
   logic unusedCfgRdy;

   assign unusedCfgRdy = ^CCUITF_CfgRdy;
   assign headGo       = 1'b1;
`endif

   always_comb begin
      stateNxt   = state;
      beatCntNxt = beatCnt;
      accept     = 1'b0;
      fwd        = 1'b0;
      fwdLast    = 1'b0;
      errNxt     = 1'b0;
      case (state)
         ST_IDLE: begin
            if (SRCITF_IsaVld) stateNxt = ST_HEAD;
         end
         ST_HEAD: begin
            if (!SRCITF_IsaVld) begin
               stateNxt = ST_IDLE;
            end else if (outFree && headGo) begin
               accept = 1'b1;
               if (!headLegal) begin
                  errNxt = 1'b1;
               end else begin
                  fwd = 1'b1;
                  if (headLen > 5'd1) begin
                     stateNxt   = ST_BODY;
                     beatCntNxt = headLen - 5'd1;
                  end else begin
                     fwdLast = 1'b1;
                  end
               end
            end
         end
         ST_BODY: begin
            // Body words are forwarded verbatim; their low byte is payload, not an opcode.
            if (SRCITF_IsaVld && outFree) begin
               accept     = 1'b1;
               fwd        = 1'b1;
               beatCntNxt = beatCnt - 5'd1;
               if (beatCnt == 5'd1) begin
                  fwdLast  = 1'b1;
                  stateNxt = ST_HEAD;
               end
            end
         end
         default: stateNxt = ST_IDLE;
      endcase
   end

   assign ITFSRC_IsaRdy = accept && !rst;
   assign ITFMON_State  = state;

   always_ff @(posedge clk) begin
      if (rst) begin
         state               <= ST_IDLE;
         beatCnt             <= '0;
         ITFCCU_ISARdDat     <= '0;
         ITFCCU_ISARdDatVld  <= 1'b0;
         ITFCCU_ISARdDatLast <= 1'b0;
         ITFMON_IsaCnt       <= '0;
         ITFMON_Err          <= 1'b0;
      end else begin
         state      <= stateNxt;
         beatCnt    <= beatCntNxt;
         ITFMON_Err <= errNxt;
         if (fwd) begin
            ITFCCU_ISARdDat     <= SRCITF_IsaDat;
            ITFCCU_ISARdDatVld  <= 1'b1;
            ITFCCU_ISARdDatLast <= fwdLast;
         end else if (ITFCCU_ISARdDatVld && CCUITF_ISARdDatRdy) begin
            ITFCCU_ISARdDatVld  <= 1'b0;
            ITFCCU_ISARdDatLast <= 1'b0;
         end
         if (ITFCCU_ISARdDatVld && CCUITF_ISARdDatRdy && ITFCCU_ISARdDatLast) begin
            ITFMON_IsaCnt <= ITFMON_IsaCnt + CNT_WIDTH'(1);
         end
      end
   end

endmodule

// File: tb/tb_itf_isa_tx.sv
// Directed bench for itf_isa_tx: inputs change on the falling edge, outputs are sampled 1 ns later.
// Gate scenario checks gating when ITF_ISA_TX_CFGRDY_GATE_EN is defined, ungated acceptance otherwise.
module tb_itf_isa_tx;

   logic         clk;
   logic         rst;
   logic [127:0] SRCITF_IsaDat;
   logic         SRCITF_IsaVld;
   logic         ITFSRC_IsaRdy;
   logic [5:0]   CCUITF_CfgRdy;
   logic [127:0] ITFCCU_ISARdDat;
   logic         ITFCCU_ISARdDatVld;
   logic         ITFCCU_ISARdDatLast;
   logic         CCUITF_ISARdDatRdy;
   logic [15:0]  ITFMON_IsaCnt;
   logic         ITFMON_Err;
   logic [1:0]   ITFMON_State;

   itf_isa_tx dut (
      .clk                 (clk),
      .rst                 (rst),
      .SRCITF_IsaDat       (SRCITF_IsaDat),
      .SRCITF_IsaVld       (SRCITF_IsaVld),
      .ITFSRC_IsaRdy       (ITFSRC_IsaRdy),
      .CCUITF_CfgRdy       (CCUITF_CfgRdy),
      .ITFCCU_ISARdDat     (ITFCCU_ISARdDat),
      .ITFCCU_ISARdDatVld  (ITFCCU_ISARdDatVld),
      .ITFCCU_ISARdDatLast (ITFCCU_ISARdDatLast),
      .CCUITF_ISARdDatRdy  (CCUITF_ISARdDatRdy),
      .ITFMON_IsaCnt       (ITFMON_IsaCnt),
      .ITFMON_Err          (ITFMON_Err),
      .ITFMON_State        (ITFMON_State)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   int stallBad = 0;

   logic [127:0] srcQ[$];
   logic [127:0] capDat[$];
   logic         capLast[$];
   int           capCyc[$];
   int           accCyc[$];
   logic         rdyLog[$];
   logic         errLog[$];
   logic         holdPend = 1'b0;
   logic [127:0] holdDat;
   logic         holdLast;

   function automatic logic [127:0] mkw(input logic [7:0] op, input logic [31:0] tag);
      mkw = {tag, 88'h0, op};
   endfunction

   function automatic int countOnes(input logic q[$]);
      int n = 0;
      foreach (q[i]) if (q[i] === 1'b1) n++;
      return n;
   endfunction

   task automatic clearLogs();
      capDat.delete(); capLast.delete(); capCyc.delete();
      accCyc.delete(); rdyLog.delete(); errLog.delete();
   endtask

   // One clock: observe at +1 ns, advance to the next falling edge, retire any accepted source word.
   task automatic tick();
      logic srcFire;
      #1;
      if (holdPend && (ITFCCU_ISARdDatVld !== 1'b1 || ITFCCU_ISARdDat !== holdDat ||
                       ITFCCU_ISARdDatLast !== holdLast)) stallBad++;
      holdPend = ITFCCU_ISARdDatVld && !CCUITF_ISARdDatRdy;
      holdDat  = ITFCCU_ISARdDat;
      holdLast = ITFCCU_ISARdDatLast;
      rdyLog.push_back(ITFSRC_IsaRdy);
      errLog.push_back(ITFMON_Err);
      srcFire = SRCITF_IsaVld && ITFSRC_IsaRdy;
      if (srcFire) accCyc.push_back(cyc);
      if (ITFCCU_ISARdDatVld && CCUITF_ISARdDatRdy) begin
         capDat.push_back(ITFCCU_ISARdDat);
         capLast.push_back(ITFCCU_ISARdDatLast);
         capCyc.push_back(cyc);
      end
      @(negedge clk);
      cyc++;
      if (srcFire && srcQ.size() != 0) void'(srcQ.pop_front());
   endtask

   // rdyMode 0: downstream always ready; 1: ready toggles 1/0 every cycle.
   task automatic run(input int n, input int rdyMode);
      for (int c = 0; c < n; c++) begin
         SRCITF_IsaVld      = (srcQ.size() != 0);
         SRCITF_IsaDat      = (srcQ.size() != 0) ? srcQ[0] : 128'h0;
         CCUITF_ISARdDatRdy = (rdyMode == 0) ? 1'b1 : ((c % 2) == 0);
         tick();
      end
   endtask

   task automatic do_reset();
      rst = 1'b1; SRCITF_IsaVld = 1'b1; SRCITF_IsaDat = mkw(8'h00, 32'hDEAD0000);
      CCUITF_ISARdDatRdy = 1'b1;
      tick();
      rst = 1'b0; SRCITF_IsaVld = 1'b0; holdPend = 1'b0;
      srcQ.delete(); clearLogs();
   endtask

   task automatic test_reset();
      rst = 1'b1; SRCITF_IsaVld = 1'b1; SRCITF_IsaDat = mkw(8'h01, 32'h0BAD0BAD);
      CCUITF_ISARdDatRdy = 1'b0; CCUITF_CfgRdy = 6'h3F;
      @(negedge clk); @(negedge clk);
      #1;
      checks++; if (ITFSRC_IsaRdy !== 1'b0) begin errors++; $display("FAIL reset_isardy got %0b want 0", ITFSRC_IsaRdy); end
      checks++; if (ITFCCU_ISARdDatVld !== 1'b0) begin errors++; $display("FAIL reset_vld got %0b want 0", ITFCCU_ISARdDatVld); end
      checks++; if (ITFCCU_ISARdDatLast !== 1'b0) begin errors++; $display("FAIL reset_last got %0b want 0", ITFCCU_ISARdDatLast); end
      checks++; if (ITFCCU_ISARdDat !== 128'h0) begin errors++; $display("FAIL reset_dat got %0h want 0", ITFCCU_ISARdDat); end
      checks++; if (ITFMON_State !== 2'd0) begin errors++; $display("FAIL reset_state got %0d want 0", ITFMON_State); end
      checks++; if (ITFMON_IsaCnt !== 16'd0) begin errors++; $display("FAIL reset_cnt got %0d want 0", ITFMON_IsaCnt); end
      checks++; if (ITFMON_Err !== 1'b0) begin errors++; $display("FAIL reset_err got %0b want 0", ITFMON_Err); end
      @(negedge clk);
      rst = 1'b0; SRCITF_IsaVld = 1'b0; CCUITF_ISARdDatRdy = 1'b1;
   endtask

   task automatic test_knn();
      logic [127:0] h, b;
      h = mkw(8'h01, 32'h4B4E0001);
      b = mkw(8'h07, 32'h4B4E0002);
      clearLogs(); srcQ = {h, b};
      run(6, 0);
      checks++; if (capDat.size() != 2) begin errors++; $display("FAIL knn_beats got %0d want 2", capDat.size()); end
      if (capDat.size() == 2) begin
         checks++; if (capDat[0] !== h || capDat[1] !== b) begin errors++; $display("FAIL knn_data got %0h,%0h want %0h,%0h", capDat[0], capDat[1], h, b); end
         checks++; if (capLast[0] !== 1'b0 || capLast[1] !== 1'b1) begin errors++; $display("FAIL knn_last got %0b%0b want 01", capLast[0], capLast[1]); end
      end
      if (accCyc.size() == 2 && capCyc.size() == 2) begin
         checks++; if (capCyc[0] != accCyc[0] + 1 || capCyc[1] != accCyc[1] + 1) begin
            errors++; $display("FAIL knn_latency got %0d,%0d want 1,1", capCyc[0] - accCyc[0], capCyc[1] - accCyc[1]); end
      end else begin
         checks++; errors++; $display("FAIL knn_latency got acc=%0d cap=%0d want 2,2", accCyc.size(), capCyc.size());
      end
      checks++; if (ITFMON_IsaCnt !== 16'd1) begin errors++; $display("FAIL knn_cnt got %0d want 1", ITFMON_IsaCnt); end
   endtask

   task automatic test_fps();
      logic [127:0] exp[$];
      int nLast;
      clearLogs(); stallBad = 0;
      exp.push_back(mkw(8'h00, 32'hF0500000));
      for (int i = 1; i < 16; i++) exp.push_back(mkw(8'(i), 32'hF0500000 + i));
      srcQ = exp;
      run(60, 1);
      checks++; if (capDat.size() != 16) begin errors++; $display("FAIL fps_beats got %0d want 16", capDat.size()); end
      for (int i = 0; i < 16 && i < capDat.size(); i++) begin
         checks++; if (capDat[i] !== exp[i]) begin errors++; $display("FAIL fps_beat%0d got %0h want %0h", i, capDat[i], exp[i]); end
      end
      nLast = countOnes(capLast);
      checks++; if (nLast != 1 || capLast.size() != 16 || capLast[15] !== 1'b1) begin
         errors++; $display("FAIL fps_last got count %0d want 1 on beat 16", nLast); end
      checks++; if (stallBad != 0) begin errors++; $display("FAIL fps_stall_stable got %0d changes want 0", stallBad); end
      checks++; if (ITFMON_IsaCnt !== 16'd2) begin errors++; $display("FAIL fps_cnt got %0d want 2", ITFMON_IsaCnt); end
   endtask

   task automatic test_illegal();
      logic [127:0] m;
      m = mkw(8'h05, 32'h4D4F4E00);
      clearLogs();
      srcQ = {mkw(8'h07, 32'hBADBAD00), m};
      run(8, 0);
      checks++; if (countOnes(errLog) != 1) begin errors++; $display("FAIL illegal_err_pulses got %0d want 1", countOnes(errLog)); end
      checks++; if (capDat.size() != 1) begin errors++; $display("FAIL illegal_fwd_beats got %0d want 1", capDat.size()); end
      if (capDat.size() >= 1) begin
         checks++; if (capDat[0] !== m || capLast[0] !== 1'b1) begin errors++; $display("FAIL illegal_mon got %0h last %0b want %0h last 1", capDat[0], capLast[0], m); end
      end
      checks++; if (ITFMON_IsaCnt !== 16'd3) begin errors++; $display("FAIL illegal_cnt got %0d want 3", ITFMON_IsaCnt); end
   endtask

   task automatic test_cfg_gate();
      logic [127:0] s[$];
      s = {mkw(8'h02, 32'h53590000), mkw(8'h02, 32'h53590001), mkw(8'h05, 32'h53590002)};
      clearLogs(); srcQ = s;
      CCUITF_CfgRdy = 6'b111011;
      run(6, 0);
`ifdef ITF_ISA_TX_CFGRDY_GATE_EN
      checks++; if (countOnes(rdyLog) != 0) begin errors++; $display("FAIL gate_isardy got %0d ready cycles want 0", countOnes(rdyLog)); end
      checks++; if (capDat.size() != 0) begin errors++; $display("FAIL gate_held got %0d beats want 0", capDat.size()); end
      checks++; if (ITFMON_State !== 2'd1) begin errors++; $display("FAIL gate_state got %0d want 1", ITFMON_State); end
`else
      checks++; if (countOnes(rdyLog) != 3) begin errors++; $display("FAIL nogate_isardy got %0d ready cycles want 3", countOnes(rdyLog)); end
      checks++; if (capDat.size() != 3) begin errors++; $display("FAIL nogate_beats got %0d want 3", capDat.size()); end
`endif
      CCUITF_CfgRdy = 6'h3F;
      run(8, 0);
      checks++; if (capDat.size() != 3) begin errors++; $display("FAIL gate_beats got %0d want 3", capDat.size()); end
      if (capDat.size() == 3) begin
         checks++; if (capDat[0] !== s[0] || capDat[1] !== s[1] || capDat[2] !== s[2]) begin errors++; $display("FAIL gate_data got %0h want %0h", capDat[2], s[2]); end
         checks++; if ({capLast[0], capLast[1], capLast[2]} !== 3'b001) begin errors++; $display("FAIL gate_last got %0b%0b%0b want 001", capLast[0], capLast[1], capLast[2]); end
      end
      checks++; if (ITFMON_IsaCnt !== 16'd4) begin errors++; $display("FAIL gate_cnt got %0d want 4", ITFMON_IsaCnt); end
   endtask

   task automatic test_reset_mid();
      logic [127:0] g0, g1;
      clearLogs();
      for (int i = 0; i < 9; i++) srcQ.push_back(mkw((i == 0) ? 8'h03 : 8'h11, 32'h504F0000 + i));
      run(4, 0);
      rst = 1'b1; SRCITF_IsaVld = 1'b1; SRCITF_IsaDat = srcQ[0]; CCUITF_ISARdDatRdy = 1'b0;
      tick();
      rst = 1'b0; holdPend = 1'b0; srcQ.delete();
      SRCITF_IsaVld = 1'b0; CCUITF_ISARdDatRdy = 1'b1;
      #1;
      checks++; if (ITFCCU_ISARdDatVld !== 1'b0) begin errors++; $display("FAIL rstmid_vld got %0b want 0", ITFCCU_ISARdDatVld); end
      checks++; if (ITFMON_State !== 2'd0) begin errors++; $display("FAIL rstmid_state got %0d want 0", ITFMON_State); end
      checks++; if (ITFMON_IsaCnt !== 16'd0) begin errors++; $display("FAIL rstmid_cnt got %0d want 0", ITFMON_IsaCnt); end
      checks++; if (capDat.size() != 2) begin errors++; $display("FAIL rstmid_pre_beats got %0d want 2", capDat.size()); end
      g0 = mkw(8'h04, 32'h47490000);
      g1 = mkw(8'h04, 32'h47490001);
      clearLogs(); srcQ = {g0, g1};
      run(6, 0);
      checks++; if (capDat.size() != 2) begin errors++; $display("FAIL gic_beats got %0d want 2", capDat.size()); end
      if (capDat.size() == 2) begin
         checks++; if (capDat[0] !== g0 || capDat[1] !== g1 || capLast[0] !== 1'b0 || capLast[1] !== 1'b1) begin
            errors++; $display("FAIL gic_data got %0h/%0b %0h/%0b", capDat[0], capLast[0], capDat[1], capLast[1]); end
      end
      checks++; if (ITFMON_IsaCnt !== 16'd1) begin errors++; $display("FAIL gic_cnt got %0d want 1", ITFMON_IsaCnt); end
   endtask

   task automatic test_back_to_back();
      logic [127:0] w[$];
      do_reset();
      w = {mkw(8'h05, 32'hB2B00000), mkw(8'h05, 32'hB2B00001), mkw(8'h01, 32'hB2B00002), mkw(8'h05, 32'hB2B00003)};
      srcQ = w;
      run(8, 0);
      checks++; if (capDat.size() != 4) begin errors++; $display("FAIL b2b_beats got %0d want 4", capDat.size()); end
      if (capDat.size() == 4) begin
         checks++; if ({capLast[0], capLast[1], capLast[2], capLast[3]} !== 4'b1101) begin
            errors++; $display("FAIL b2b_last got %0b%0b%0b%0b want 1101", capLast[0], capLast[1], capLast[2], capLast[3]); end
         checks++; if (capCyc[1] != capCyc[0] + 1 || capCyc[2] != capCyc[0] + 2 || capCyc[3] != capCyc[0] + 3) begin
            errors++; $display("FAIL b2b_consecutive got span %0d want 3", capCyc[3] - capCyc[0]); end
         checks++; if (capDat[3] !== w[3]) begin errors++; $display("FAIL b2b_data got %0h want %0h", capDat[3], w[3]); end
      end
      checks++; if (ITFMON_IsaCnt !== 16'd3) begin errors++; $display("FAIL b2b_cnt got %0d want 3", ITFMON_IsaCnt); end
   endtask

   initial begin
      rst = 1'b1; SRCITF_IsaVld = 1'b0; SRCITF_IsaDat = 128'h0;
      CCUITF_CfgRdy = 6'h3F; CCUITF_ISARdDatRdy = 1'b1;
      @(negedge clk);
      test_reset();
      test_knn();
      test_fps();
      test_illegal();
      test_cfg_gate();
      test_reset_mid();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/itf_isa_tx.md
ITF_ISA_TX -- requirements
Module: itf_isa_tx

Interface
REQ-001 SHALL have parameter PORT_WIDTH, default 128, meaning ISA beat width in bits.
REQ-002 SHALL have parameter OPNUM, default 6, meaning number of config targets (FPS, KNN, SYA, POL, GIC, MON).
REQ-003 SHALL have parameter OPCODE_WIDTH, default 8, meaning opcode field in bits [7:0] of each head beat.
REQ-004 SHALL have parameter CNT_WIDTH, default 16, meaning width of the sent-instruction counter.
REQ-005 SHALL have port clk, input, 1, sole clock; all logic on its rising edge.
REQ-006 SHALL have port rst, input, 1, reset; it is synchronous and active-high.
REQ-007 SHALL have ports SRCITF_IsaDat/Vld input (PORT_WIDTH/1) and ITFSRC_IsaRdy output 1, the upstream ISA word stream from the DRAM read path.
REQ-008 SHALL have port CCUITF_CfgRdy, input, OPNUM, per-target ready from the config unit.
REQ-009 SHALL have ports ITFCCU_ISARdDat output PORT_WIDTH, ITFCCU_ISARdDatVld output 1, ITFCCU_ISARdDatLast output 1, and CCUITF_ISARdDatRdy input 1, the downstream ISA stream.
REQ-010 SHALL have ports ITFMON_IsaCnt output CNT_WIDTH (instructions completed), ITFMON_Err output 1 (illegal-opcode pulse), ITFMON_State output 2 (FSM state).

Function
REQ-011 SHALL use fixed beats-per-instruction by opcode: 0 FPS=16, 1 KNN=2, 2 SYA=3, 3 POL=9, 4 GIC=2, 5 MON=1; opcode >= OPNUM is illegal.
REQ-012 SHALL hold a one-entry registered output stage (data, Vld, Last); input-to-output latency is exactly 1 cycle.
REQ-013 SHALL assert ITFSRC_IsaRdy when the FSM accepts a beat and the output stage is empty or is handshaking this cycle (Vld & Rdy).
REQ-014 SHALL keep ITFCCU_ISARdDat/Vld/Last stable while Vld=1 and CCUITF_ISARdDatRdy=0; Vld drops only after handshake with no new beat loaded.
REQ-015 SHALL implement states IDLE(0), HEAD(1), BODY(2): IDLE->HEAD when SRCITF_IsaVld; HEAD accepts head beat -> BODY if length>1, else stays HEAD; BODY->HEAD when the final beat is accepted and SRCITF_IsaVld, else ->IDLE.
REQ-016 SHALL load a beat counter with length-1 on head acceptance, decrement on each body beat accepted, and set output Last on the beat where counter reaches 0 (head beat itself for length 1).
REQ-017 SHALL on an illegal head opcode consume the word without forwarding, pulse ITFMON_Err for one cycle, and remain in HEAD/IDLE.
REQ-018 SHALL increment ITFMON_IsaCnt on each downstream handshake with Last=1, wrapping modulo 2^CNT_WIDTH.
REQ-019 SHALL never forward body beats in HEAD nor head-decode in BODY; input opcode bits in body beats are ignored.

Reset
REQ-020 SHALL on rst=1 at a clock edge clear state to IDLE, counter and ITFMON_IsaCnt to 0, output Vld/Last/Err to 0, data to 0, ITFSRC_IsaRdy to 0; a partly sent instruction is discarded.
REQ-021 SHALL ignore all inputs in a cycle where rst=1.

Configuration
REQ-022 SHALL with macro ITF_ISA_TX_CFGRDY_GATE_EN defined withhold head-beat acceptance until CCUITF_CfgRdy[opcode]=1 (illegal opcodes are dropped ungated); without it, heads are accepted regardless of CCUITF_CfgRdy.

Structure
REQ-023 SHALL place opcode encodings, per-opcode beat lengths, OPCODE_WIDTH and state encodings in the shared ISA package used by the config unit.
REQ-024 SHALL be a single module; the output stage is inline, no sub-module.

Verification
REQ-025 SHALL cover: KNN head 0x..01 + 1 body beat, Rdy=1 -> 2 downstream beats, Last on beat 2, IsaCnt 0->1.
REQ-026 SHALL cover: FPS 16 beats with Rdy toggled 1/0 each cycle -> 16 beats in order, data stable during stalls, Last only on beat 16.
REQ-027 SHALL cover: opcode 0x07 head -> word consumed, nothing forwarded, Err high 1 cycle, next MON (opcode 5) sent with Last=1.
REQ-028 SHALL cover: macro defined, SYA head with CfgRdy[2]=0 for 5 cycles -> IsaRdy=0 for those cycles, then 3 beats once CfgRdy[2]=1.
REQ-029 SHALL cover: rst=1 during beat 4 of POL -> next cycle Vld=0, state IDLE, IsaCnt=0; fresh GIC instruction then sends 2 beats correctly.
REQ-030 SHALL cover: back-to-back MON, MON, KNN with continuous Vld/Rdy -> 4 beats on consecutive cycles, Last on beats 1, 2, 4, IsaCnt=3.
